// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end for one shared combinational ALU.
// Requests are granted one at a time. Each op passes through IDLE -> EXEC -> RESP,
// and every response carries the index of the requester that issued it.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*32-1:0]   req_a_i,
    input  logic [NREQ*32-1:0]   req_b_i,
    input  logic [NREQ*3-1:0]    req_f_i,
    output logic [31:0]          alu_a_o,
    output logic [31:0]          alu_b_o,
    output logic [3:0]           alu_f_o,
    input  logic [31:0]          alu_y_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [31:0]          resp_y_o,
    output logic [IDW-1:0]       resp_id_o,
    output logic                 resp_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [2:0] F_ILLEGAL = 3'b011;

    // Function code 3'b011 has no ALU meaning and is reported as an error.
    function automatic logic is_illegal_f(input logic [2:0] f);
        return (f == F_ILLEGAL);
    endfunction

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] gid_q;
    logic [31:0]    alu_a_q;
    logic [31:0]    alu_b_q;
    logic [2:0]     alu_f_q;
    logic           resp_valid_q;
    logic [31:0]    resp_y_q;
    logic [IDW-1:0] resp_id_q;
    logic           resp_err_q;

    logic           found_s;
    logic [IDW-1:0] gnt_s;

    // Round-robin pick: first valid requester after the one served most recently.
    always_comb begin
        found_s = 1'b0;
        gnt_s   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found_s && req_valid_i[(int'(rr_ptr_q) + k) % NREQ]) begin
                found_s = 1'b1;
                gnt_s   = IDW'((int'(rr_ptr_q) + k) % NREQ);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Accept strobe is combinational so the requester sees it in the grant cycle itself.
    always_comb begin
        req_ready_o = '0;
        if (state_q == ST_IDLE && found_s) begin
            req_ready_o[gnt_s] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
    end

    // Next-state logic for the single-op-in-flight sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture at grant; operands are kept afterwards so the ALU inputs stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q  <= 32'd0;
            alu_b_q  <= 32'd0;
            alu_f_q  <= 3'd0;
            gid_q    <= '0;
            rr_ptr_q <= IDW'(NREQ - 1);
        end else if (state_q == ST_IDLE && found_s) begin
            alu_a_q  <= req_a_i[32*int'(gnt_s) +: 32];
            alu_b_q  <= req_b_i[32*int'(gnt_s) +: 32];
            alu_f_q  <= req_f_i[3*int'(gnt_s) +: 3];
            gid_q    <= gnt_s;
            rr_ptr_q <= gnt_s;
        end
    end

    // Response register: loaded from the ALU in EXEC, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_y_q     <= 32'd0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            resp_valid_q <= 1'b1;
            resp_id_q    <= gid_q;
            resp_err_q   <= is_illegal_f(alu_f_q);
            resp_y_q     <= is_illegal_f(alu_f_q) ? 32'd0 : alu_y_i;
        end else if (state_q == ST_RESP && resp_ready_i) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_f_o      = {1'b0, alu_f_q};
    assign resp_valid_o = resp_valid_q;
    assign resp_y_o     = resp_y_q;
    assign resp_id_o    = resp_id_q;
    assign resp_err_o   = resp_err_q;

endmodule
